// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- instruction fetch PC sequencer
//
// Holds the program counter and issues instruction fetches. The PC advances
// by 4 on each accepted fetch. It can be redirected to a branch or jump
// target. It stops permanently when decode sees a HALT.
//
// Ports
//   CLK            in   clock, all state updates on its rising edge
//   nRST           in   asynchronous active-low reset
//   ihit           in   imemload is valid for the current imemaddr
//   stall          in   hazard unit holds fetch; IF/ID does not capture
//   redirect_en    in   a later stage resolved a taken branch/jump
//   redirect_addr  in   [31:0] target PC, valid with redirect_en
//   halt           in   decode holds a HALT instruction
//   imemREN        out  instruction read enable
//   imemaddr       out  [31:0] fetch address (current PC)
//   NPC            out  [31:0] PC+4 for the IF/ID latch
//   fetch_valid    out  fetched word accepted, PC advances this cycle
//   flush          out  IF/ID contents are wrong-path, clear this cycle
//
// State       | meaning
// ------------+-------------------------------------------------------------
// FETCH       | normal sequential fetch
// REDIR_WAIT  | redirect arrived during a miss; imemaddr is held until the
//             | outstanding access returns, then the PC jumps to pend_q
// HALTED      | HALT retired; no fetch, all inputs ignored until reset
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] NPC,
  output logic        fetch_valid,
  output logic        flush
);

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    REDIR_WAIT = 2'd1,
    HALTED     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        fetch_valid_raw;
  logic        flush_raw;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      pend_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  // Priority within an active state: redirect > stall > halt > ihit.
  // A halt arriving under stall waits until the stall clears, so a held
  // pipeline sees no side effects.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pend_d          = pend_q;
    fetch_valid_raw = 1'b0;
    flush_raw       = 1'b0;

    case (state_q)
      FETCH: begin
        if (redirect_en) begin
          flush_raw = 1'b1;
          if (ihit) begin
            pc_d = redirect_addr;
          end else begin
            // keep imemaddr stable for the outstanding access
            pend_d  = redirect_addr;
            state_d = REDIR_WAIT;
          end
        end else if (stall) begin
          // hold
        end else if (halt) begin
          state_d = HALTED;
          pend_d  = 32'h0;
        end else if (ihit) begin
          fetch_valid_raw = 1'b1;
          pc_d            = pc_q + 32'd4;
        end
      end

      REDIR_WAIT: begin
        if (redirect_en) begin
          // newest redirect always wins over the older pending target
          flush_raw = 1'b1;
          pend_d    = redirect_addr;
          if (ihit) begin
            pc_d    = redirect_addr;
            state_d = FETCH;
          end
        end else if (stall) begin
          // hold
        end else if (halt) begin
          state_d = HALTED;
          pend_d  = 32'h0;
        end else if (ihit) begin
          pc_d    = pend_q;
          state_d = FETCH;
        end
      end

      HALTED: begin
        // terminal until reset
      end

      default: begin
        // unreachable encoding: recover to a clean fetch
        state_d = FETCH;
        pend_d  = 32'h0;
      end
    endcase
  end

  assign imemaddr = pc_q;
  assign NPC      = pc_q + 32'd4;
  assign imemREN  = (state_q != HALTED);

  // Reset forces the handshake outputs low even though inputs may toggle.
  assign fetch_valid = fetch_valid_raw & nRST;
  assign flush       = flush_raw & nRST;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, stall, redirect_en, halt;
  logic [31:0] redirect_addr;
  logic        imemREN, fetch_valid, flush;
  logic [31:0] imemaddr, NPC;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .NPC(NPC),
    .fetch_valid(fetch_valid), .flush(flush)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ihit;
    logic        stall;
    logic        re;
    logic [31:0] raddr;
    logic        halt;
    logic [31:0] e_addr;
    logic        e_fv;
    logic        e_fl;
    logic        e_ren;
  } vec_t;

  vec_t vecs[12];

  // reference model state
  logic [31:0] m_pc, m_pend;
  bit          m_wait, m_halt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic i, input logic s, input logic r,
                       input logic [31:0] ra, input logic h);
    ihit = i; stall = s; redirect_en = r; redirect_addr = ra; halt = h;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 32'h0, 0);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    m_pc = 32'h0; m_pend = 32'h0; m_wait = 0; m_halt = 0;
  endtask

  // single-cycle outputs check against explicit expectations
  task automatic chk_out(input string tag, input logic [31:0] a, input logic fv,
                         input logic fl, input logic ren);
    chk({tag, ".addr"}, imemaddr, a);
    chk({tag, ".npc"}, NPC, a + 32'd4);
    chk({tag, ".fv"}, {31'h0, fetch_valid}, {31'h0, fv});
    chk({tag, ".flush"}, {31'h0, flush}, {31'h0, fl});
    chk({tag, ".ren"}, {31'h0, imemREN}, {31'h0, ren});
  endtask

  initial begin
    nRST = 1'b0;
    drive(0, 0, 0, 32'h0, 0);
    @(negedge CLK);

    // ---------------- reset state ----------------
    drive(1, 1, 1, 32'hDEAD_BEE0, 1);
    chk_out("reset", 32'h0, 0, 0, 1);
    nRST = 1'b1;
    drive(0, 0, 0, 32'h0, 0);

    // ---------------- table-driven vectors ----------------
    //          ihit st re raddr         halt  addr          fv fl ren
    vecs[0]  = '{1, 0, 0, 32'h0,       0, 32'h0,       1, 0, 1};
    vecs[1]  = '{1, 0, 0, 32'h0,       0, 32'h4,       1, 0, 1};
    vecs[2]  = '{1, 1, 0, 32'h0,       0, 32'h8,       0, 0, 1};
    vecs[3]  = '{1, 1, 0, 32'h0,       0, 32'h8,       0, 0, 1};
    vecs[4]  = '{1, 0, 0, 32'h0,       0, 32'h8,       1, 0, 1};
    vecs[5]  = '{1, 0, 0, 32'h0,       0, 32'hC,       1, 0, 1};
    vecs[6]  = '{0, 0, 0, 32'h0,       0, 32'h10,      0, 0, 1};
    vecs[7]  = '{1, 0, 1, 32'h40,      0, 32'h10,      0, 1, 1};
    vecs[8]  = '{1, 1, 1, 32'h60,      0, 32'h40,      0, 1, 1};
    vecs[9]  = '{1, 0, 0, 32'h0,       0, 32'h60,      1, 0, 1};
    vecs[10] = '{1, 0, 1, 32'h100,     1, 32'h64,      0, 1, 1};
    vecs[11] = '{1, 0, 0, 32'h0,       0, 32'h100,     1, 0, 1};
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].ihit, vecs[i].stall, vecs[i].re, vecs[i].raddr, vecs[i].halt);
      chk_out($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_fv,
              vecs[i].e_fl, vecs[i].e_ren);
      tick();
    end
    drive(0, 0, 0, 32'h0, 0);
    chk_out("vec_end", 32'h104, 0, 0, 1);

    // ---------------- redirect while missing ----------------
    do_reset();
    drive(1, 0, 1, 32'd20, 0); tick();
    drive(0, 0, 1, 32'h80, 0);
    chk_out("miss.r1", 32'd20, 0, 1, 1); tick();
    drive(0, 0, 1, 32'h90, 0);
    chk_out("miss.r2", 32'd20, 0, 1, 1); tick();
    drive(0, 0, 0, 32'h0, 0);
    chk_out("miss.wait", 32'd20, 0, 0, 1); tick();
    drive(1, 0, 0, 32'h0, 0);
    chk_out("miss.hit", 32'd20, 0, 0, 1); tick();
    drive(0, 0, 0, 32'h0, 0);
    chk_out("miss.land", 32'h90, 0, 0, 1);

    // ---------------- wrap of NPC ----------------
    do_reset();
    drive(1, 0, 1, 32'hFFFF_FFFC, 0); tick();
    drive(0, 0, 0, 32'h0, 0);
    chk("wrap.npc", NPC, 32'h0);
    drive(1, 0, 0, 32'h0, 0); tick();
    chk("wrap.pc", imemaddr, 32'h0);

    // ---------------- halt is terminal ----------------
    do_reset();
    drive(1, 0, 1, 32'd24, 0); tick();
    drive(1, 0, 0, 32'h0, 1);
    chk_out("halt.take", 32'd24, 0, 0, 1); tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'($urandom), 1'($urandom), i[0], 32'h200, 1'($urandom));
      chk_out($sformatf("halt.c%0d", i), 32'd24, 0, 0, 0);
      tick();
    end

    // ---------------- reset in the middle of REDIR_WAIT ----------------
    do_reset();
    drive(1, 0, 1, 32'h20, 0); tick();
    drive(0, 0, 1, 32'h80, 0); tick();
    drive(1, 0, 1, 32'h44, 0);
    #2 nRST = 1'b0;
    #1 chk_out("rstmid", 32'h0, 0, 0, 1);
    tick();
    nRST = 1'b1;
    drive(1, 0, 0, 32'h0, 0);
    chk_out("rstmid.first", 32'h0, 1, 0, 1); tick();
    chk("rstmid.next", imemaddr, 32'h4);

    // ---------------- randomized against reference model ----------------
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic        ri, rs, rr, rh;
      logic [31:0] ra;
      bit          e_fv, e_fl;
      if (m_halt && ($urandom_range(0, 7) == 0)) do_reset();
      ri = 1'($urandom_range(0, 3) != 0);
      rs = 1'($urandom_range(0, 4) == 0);
      rr = 1'($urandom_range(0, 5) == 0);
      rh = 1'($urandom_range(0, 40) == 0);
      ra = {$urandom_range(0, 32'h3FFF), 2'b00};
      drive(ri, rs, rr, ra, rh);
      e_fv = !m_halt && !m_wait && ri && !rs && !rr && !rh;
      e_fl = rr && !m_halt;
      chk_out($sformatf("rnd%0d", n), m_pc, e_fv, e_fl, !m_halt);
      tick();
      // model: redirect beats stall, stall beats halt, halt beats advance
      if (!m_halt) begin
        if (rr) begin
          if (ri) begin m_pc = ra; m_wait = 0; end
          else begin m_pend = ra; m_wait = 1; end
        end else if (rs) begin
        end else if (rh) begin
          m_halt = 1; m_wait = 0; m_pend = 0;
        end else if (ri) begin
          m_pc = m_wait ? m_pend : m_pc + 32'd4;
          m_wait = 0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

endmodule
